rr_arbiter_ctrl: RTL
====================

// Module: rr_arbiter_ctrl
//
// PURPOSE
//  Clocked round-robin arbiter controller that shares one resource among N requesters.
//  It replaces fixed daisy-chain priority with rotating priority, and adds grant hold,
//  explicit release, a hold-timeout and a break-before-make gap cycle.
//  It sits between requester blocks and the shared resource; g drives the resource select.
//
// PARAMETERS
//  N        4   number of requesters (N >= 1)
//  IW       2   width of gid; 2**IW >= N
//  MAXHOLD  16  max consecutive grant cycles per requester; 0 disables timeout
//  TW       5   hold-timer width; 2**TW > MAXHOLD
//
// PORTS
//  clk    in   1    clock, rising edge
//  rst_n  in   1    asynchronous reset, active low
//  req    in   N    request; req[i]=1 means requester i wants the resource
//  done   in   N    release pulse; only done[gid] is honoured while granted
//  g      out  N    grant, one-hot or zero, registered
//  gid    out  IW   index of current/last grantee, registered
//  busy   out  1    1 while any grant is asserted (busy == |g)
//
// BEHAVIOUR
//  - Reset (rst_n=0, async): g=0, gid=0, busy=0, ptr=0, timer=0, state=IDLE.
//    Outputs clear immediately, without waiting for a clock edge.
//  - ptr = highest-priority index. Search order: ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//  - States:
//    - IDLE: if req != 0, the winner is the first set bit in search order.
//      Next edge: g = onehot(winner), gid = winner, timer = 0, state -> GRANT.
//      Otherwise stay in IDLE. Latency is 1 clock from sampled req to grant.
//    - GRANT: g is held stable. timer increments each cycle.
//      Release when done[gid]=1, or req[gid]=0, or (MAXHOLD != 0 and timer == MAXHOLD-1).
//      On release, next edge: g=0, busy=0, ptr=(gid+1) mod N, state -> GAP.
//      A timeout therefore gives exactly MAXHOLD grant cycles.
//    - GAP: g=0 for exactly one cycle. It arbitrates like IDLE, using the updated ptr:
//      - req != 0 -> GRANT at the next edge;
//      - req == 0 -> IDLE.
//  - gid keeps its last value while g=0.
//  - In GRANT: req and done from non-grantees are ignored; done with req low is ignored.
//  - A timed-out grantee drops to lowest priority. If it is the sole requester,
//    it is re-granted after the GAP cycle.
//  - Simultaneous done[gid] and other requests: release wins; the new grant comes 2 edges later.
//  - ptr wraps modulo N (N not a power of two: N-1 -> 0).
//  - N=1: grant/gap alternation, ptr stays 0.
//  - Reset during GRANT or GAP aborts the grant; no release bookkeeping; ptr returns to 0.
//  - Invariants: never more than one bit of g set; g never changes directly grant-to-grant.
//
// TESTING
//  1. rst_n=0 with req=4'b1111 -> g=0000, busy=0 throughout.
//     Release reset -> after first edge g=0001, gid=0.
//  2. req=4'b1111 held, done[gid] pulsed 3 cycles into each grant
//     -> grant order 0,1,2,3,0, with one g=0000 cycle between grants.
//  3. MAXHOLD=16, req=4'b0100 held, no done -> g=0100 for exactly 16 cycles,
//     g=0000 for 1 cycle, then g=0100 again.
//  4. Granted to 1; done[3]=1 -> ignored, g stays 0010.
//     Then req[1]=0 -> next edge g=0000, ptr=2.
//  5. gid=3 releases via done[3] while req=4'b1001 -> ptr wraps to 0;
//     after the gap, g=0001 (not 1000).
//  6. rst_n pulsed low mid-cycle while g=0100 -> g=0000 before the next edge;
//     after release with req=4'b0110 -> g=0010.

Source files
------------

// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter controller: rotating priority, grant hold with release/timeout,
// and a one-cycle break-before-make gap between grants.
module rr_arbiter_ctrl #(
  parameter int N       = 4,
  parameter int IW      = 2,
  parameter int MAXHOLD = 16,
  parameter int TW      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  g,
  output logic [IW-1:0] gid,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [TW-1:0] timer;
  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic          timeout;
  logic          rel;

  // Descending scan so the lowest offset from ptr (first in search order) wins.
  function automatic logic [IW:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % N;
      if (r[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  assign {win_vld, win_idx} = pick(req, ptr);
  assign timeout = (MAXHOLD != 0) && (timer == TW'(MAXHOLD - 1));
  assign rel     = done[gid] | ~req[gid] | timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      g     <= '0;
      gid   <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
      timer <= '0;
    end else begin
      case (state)
        GRANT: begin
          if (rel) begin
            g     <= '0;
            busy  <= 1'b0;
            ptr   <= (gid == IW'(N - 1)) ? '0 : gid + IW'(1);
            state <= GAP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          // IDLE and GAP arbitrate identically; GAP simply follows a release.
          if (win_vld) begin
            g     <= N'(1) << win_idx;
            gid   <= win_idx;
            busy  <= 1'b1;
            timer <= '0;
            state <= GRANT;
          end else begin
            g     <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
